// File: rtl/cache_arbiter_if.sv
// Bundles the I-cache, D-cache and physical-memory sides of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;
  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  logic [15:0]           conflict_count;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write,
    input  d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output conflict_count
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write,
    output d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  conflict_count
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter serialising I/D cache line traffic onto one
// memory port; memory-side outputs are registered at grant.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input logic            clk,
  input logic            reset,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [15:0]           cnt_q, cnt_d;

  logic i_req;
  logic d_req;
  logic pick_d;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;
  // On a conflict, favour the side that did not win last time
  assign pick_d = d_req & (~i_req | ~last_d_q);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_req && d_req && cnt_q != 16'hFFFF)
          cnt_d = cnt_q + 16'd1;
        if (pick_d) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          wr_d     = bus.d_pmem_write;
          rd_d     = ~bus.d_pmem_write;
          addr_d   = bus.d_pmem_address;
          wdata_d  = bus.d_pmem_wdata;
        end else if (i_req) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          wr_d     = 1'b0;
          rd_d     = 1'b1;
          addr_d   = bus.i_pmem_address;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.pmem_read      = rd_q;
  assign bus.pmem_write     = wr_q;
  assign bus.pmem_address   = addr_q;
  assign bus.pmem_wdata     = wdata_q;
  assign bus.conflict_count = cnt_q;
  assign bus.i_pmem_resp    = (state_q == SERVE_I) & bus.pmem_resp;
  assign bus.d_pmem_resp    = (state_q == SERVE_D) & bus.pmem_resp;
  assign bus.i_pmem_rdata   = bus.pmem_rdata;
  assign bus.d_pmem_rdata   = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_cache_arbiter;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] X5A = {16{8'h5A}};
  localparam logic [127:0] RD1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    idle_inputs();
    do_reset();

    chk("rst_rd", 128'(bus.pmem_read), 128'd0);
    chk("rst_wr", 128'(bus.pmem_write), 128'd0);
    chk("rst_addr", 128'(bus.pmem_address), 128'd0);
    chk("rst_wdata", bus.pmem_wdata, 128'd0);
    chk("rst_iresp", 128'(bus.i_pmem_resp), 128'd0);
    chk("rst_dresp", 128'(bus.d_pmem_resp), 128'd0);
    chk("rst_cnt", 128'(bus.conflict_count), 128'd0);

    // 1: lone I read, memory answers on third strobe cycle
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h1230;
    tick();
    chk("t1_rd", 128'(bus.pmem_read), 128'd1);
    chk("t1_wr", 128'(bus.pmem_write), 128'd0);
    chk("t1_addr", 128'(bus.pmem_address), 128'h1230);
    chk("t1_noresp", 128'(bus.i_pmem_resp), 128'd0);
    tick();
    chk("t1_rd2", 128'(bus.pmem_read), 128'd1);
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = RD1;
    #1;
    chk("t1_iresp", 128'(bus.i_pmem_resp), 128'd1);
    chk("t1_irdata", bus.i_pmem_rdata, RD1);
    chk("t1_dresp", 128'(bus.d_pmem_resp), 128'd0);
    tick();
    bus.pmem_resp   = 1'b0;
    bus.i_pmem_read = 1'b0;
    chk("t1_done_rd", 128'(bus.pmem_read), 128'd0);
    chk("t1_done_resp", 128'(bus.i_pmem_resp), 128'd0);
    tick();

    // 2: simultaneous I and D after reset; D wins first
    do_reset();
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h0040;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 16'h8000;
    tick();
    chk("t2_addr_d", 128'(bus.pmem_address), 128'h8000);
    chk("t2_rd_d", 128'(bus.pmem_read), 128'd1);
    chk("t2_cnt", 128'(bus.conflict_count), 128'd1);
    bus.pmem_resp = 1'b1;
    #1;
    chk("t2_dresp", 128'(bus.d_pmem_resp), 128'd1);
    chk("t2_iresp0", 128'(bus.i_pmem_resp), 128'd0);
    tick();
    bus.pmem_resp   = 1'b0;
    bus.d_pmem_read = 1'b0;
    chk("t2_done", 128'(bus.pmem_read), 128'd0);
    tick();
    chk("t2_idle", 128'(bus.pmem_read), 128'd0);
    tick();
    chk("t2_addr_i", 128'(bus.pmem_address), 128'h0040);
    chk("t2_rd_i", 128'(bus.pmem_read), 128'd1);
    chk("t2_cnt2", 128'(bus.conflict_count), 128'd1);
    bus.pmem_resp = 1'b1;
    #1;
    chk("t2_iresp", 128'(bus.i_pmem_resp), 128'd1);
    tick();
    bus.pmem_resp   = 1'b0;
    bus.i_pmem_read = 1'b0;
    tick();

    // 3: D writeback; wdata changes mid-transaction
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 16'h2000;
    bus.d_pmem_wdata   = A5;
    tick();
    chk("t3_wr", 128'(bus.pmem_write), 128'd1);
    chk("t3_rd", 128'(bus.pmem_read), 128'd0);
    chk("t3_wdata", bus.pmem_wdata, A5);
    bus.d_pmem_wdata   = X5A;
    bus.d_pmem_address = 16'h7777;
    tick();
    chk("t3_wdata2", bus.pmem_wdata, A5);
    chk("t3_addr2", 128'(bus.pmem_address), 128'h2000);
    chk("t3_rd2", 128'(bus.pmem_read), 128'd0);
    bus.pmem_resp = 1'b1;
    #1;
    chk("t3_dresp", 128'(bus.d_pmem_resp), 128'd1);
    tick();
    bus.pmem_resp    = 1'b0;
    bus.d_pmem_write = 1'b0;
    chk("t3_done", 128'(bus.pmem_write), 128'd0);
    tick();

    // 4: both sides hold requests for six transactions
    do_reset();
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h0100;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 16'h0200;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t4_addr%0d", k), 128'(bus.pmem_address),
          (k % 2 == 0) ? 128'h0200 : 128'h0100);
      chk($sformatf("t4_rd%0d", k), 128'(bus.pmem_read), 128'd1);
      bus.pmem_resp = 1'b1;
      #1;
      chk($sformatf("t4_dresp%0d", k), 128'(bus.d_pmem_resp),
          (k % 2 == 0) ? 128'd1 : 128'd0);
      chk($sformatf("t4_iresp%0d", k), 128'(bus.i_pmem_resp),
          (k % 2 == 0) ? 128'd0 : 128'd1);
      tick();
      bus.pmem_resp = 1'b0;
      chk($sformatf("t4_done%0d", k), 128'(bus.pmem_read), 128'd0);
      tick();
      chk($sformatf("t4_idle%0d", k), 128'(bus.pmem_read), 128'd0);
    end
    chk("t4_cnt", 128'(bus.conflict_count), 128'd6);
    idle_inputs();
    tick();

    // 5: reset during D writeback, then pending I is granted
    do_reset();
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 16'h3000;
    bus.d_pmem_wdata   = A5;
    tick();
    chk("t5_wr", 128'(bus.pmem_write), 128'd1);
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h4000;
    reset          = 1'b1;
    bus.pmem_resp  = 1'b1;
    #1;
    chk("t5_wr_rst", 128'(bus.pmem_write), 128'd0);
    chk("t5_dresp", 128'(bus.d_pmem_resp), 128'd0);
    chk("t5_addr_rst", 128'(bus.pmem_address), 128'd0);
    tick();
    reset            = 1'b0;
    bus.pmem_resp    = 1'b0;
    bus.d_pmem_write = 1'b0;
    tick();
    chk("t5_rd_i", 128'(bus.pmem_read), 128'd1);
    chk("t5_addr_i", 128'(bus.pmem_address), 128'h4000);
    chk("t5_cnt", 128'(bus.conflict_count), 128'd0);
    bus.pmem_resp = 1'b1;
    #1;
    chk("t5_iresp", 128'(bus.i_pmem_resp), 128'd1);
    tick();
    bus.pmem_resp   = 1'b0;
    bus.i_pmem_read = 1'b0;
    tick();

    // 6: preload the counter near saturation
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    #1;
    chk("t6_pre", 128'(bus.conflict_count), 128'hFFFE);
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h0500;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 16'h0600;
    tick();
    chk("t6_cnt1", 128'(bus.conflict_count), 128'hFFFF);
    chk("t6_addr1", 128'(bus.pmem_address), 128'h0600);
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    tick();
    tick();
    chk("t6_cnt2", 128'(bus.conflict_count), 128'hFFFF);
    chk("t6_addr2", 128'(bus.pmem_address), 128'h0500);
    bus.pmem_resp = 1'b1;
    tick();
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
